// File: rtl/dcache_pkg.sv
// Shared definitions for the direct-mapped write-back L1 data cache:
// line geometry, address field positions, miss FSM encoding and the word-merge helper.
package dcache_pkg;

  localparam int LINE_BITS      = 256;
  localparam int WORD_W         = 32;
  localparam int WORDS_PER_LINE = LINE_BITS / WORD_W;
  localparam int OFFSET_W       = 5;
  localparam int WSEL_LSB       = 2;
  localparam int WSEL_W         = OFFSET_W - WSEL_LSB;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_REFILL    = 2'd2,
    ST_FILL      = 2'd3
  } state_t;

  // Replace one 32-bit word of a line; the bit offset is {sel, 5'b0}.
  function automatic logic [LINE_BITS-1:0] merge_word(
    input logic [LINE_BITS-1:0] line,
    input logic [WSEL_W-1:0]    sel,
    input logic [WORD_W-1:0]    word
  );
    logic [LINE_BITS-1:0] result;
    result = line;
    result[{sel, 5'd0} +: WORD_W] = word;
    return result;
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Single-port tag/valid/dirty and line storage: combinational read, synchronous
// full-line write with an optional single-word merge. Only valid/dirty are cleared.
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 32,
  parameter int IDX_W     = 5,
  parameter int TAG_W     = 22
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [IDX_W-1:0]     index,
  output logic                 rd_valid,
  output logic                 rd_dirty,
  output logic [TAG_W-1:0]     rd_tag,
  output logic [LINE_BITS-1:0] rd_line,
  input  logic                 we,
  input  logic [TAG_W-1:0]     wr_tag,
  input  logic                 wr_valid,
  input  logic                 wr_dirty,
  input  logic [LINE_BITS-1:0] wr_line,
  input  logic                 merge_en,
  input  logic [WSEL_W-1:0]    merge_sel,
  input  logic [WORD_W-1:0]    merge_data
);

  logic [TAG_W-1:0]     tag_mem_r  [NUM_LINES];
  logic [LINE_BITS-1:0] data_mem_r [NUM_LINES];
  logic [NUM_LINES-1:0] valid_r;
  logic [NUM_LINES-1:0] dirty_r;
  logic [LINE_BITS-1:0] wr_data_s;

  assign rd_valid = valid_r[index];
  assign rd_dirty = dirty_r[index];
  assign rd_tag   = tag_mem_r[index];
  assign rd_line  = data_mem_r[index];

  // Line to be written, with the optional store word folded in
  always_comb begin
    wr_data_s = wr_line;
    if (merge_en) begin
      wr_data_s = merge_word(wr_line, merge_sel, merge_data);
    end else begin
      wr_data_s = wr_line;
    end
  end

  // Status bits: cleared on reset so every line starts invalid and clean
  always_ff @(posedge clk) begin
    if (clr) begin
      valid_r <= '0;
      dirty_r <= '0;
    end else if (we) begin
      valid_r[index] <= wr_valid;
      dirty_r[index] <= wr_dirty;
    end
  end

  // Tag and data storage, never cleared
  always_ff @(posedge clk) begin
    if (we && !clr) begin
      tag_mem_r[index]  <= wr_tag;
      data_mem_r[index] <= wr_data_s;
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate L1 data cache controller: hit detection,
// pipeline stall, miss FSM with dirty-line eviction and the 256-bit memory handshake.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int NUM_LINES = 32,
  parameter int ADDR_W    = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 p1_req_i,
  input  logic                 p1_write_i,
  input  logic [ADDR_W-1:0]    p1_addr_i,
  input  logic [WORD_W-1:0]    p1_data_i,
  output logic [WORD_W-1:0]    p1_data_o,
  output logic                 p1_stall_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
);

  localparam int IDX_W   = $clog2(NUM_LINES);
  localparam int TAG_LSB = OFFSET_W + IDX_W;
  localparam int TAG_W   = ADDR_W - TAG_LSB;

  state_t                  state_r;
  logic [ADDR_W-1:WSEL_LSB] addr_r;
  logic                    write_r;
  logic [WORD_W-1:0]       wdata_r;
  logic [LINE_BITS-1:0]    fill_line_r;
  logic                    mem_enable_r;
  logic                    mem_write_r;
  logic [ADDR_W-1:0]       mem_addr_r;
  logic [LINE_BITS-1:0]    mem_data_r;

  logic [ADDR_W-1:WSEL_LSB] cur_addr_s;
  logic [IDX_W-1:0]         idx_s;
  logic [TAG_W-1:0]         tag_s;
  logic [WSEL_W-1:0]        wsel_s;
  logic [ADDR_W-1:0]        line_addr_s;
  logic                     hit_s;
  logic                     idle_s;

  logic                 rd_valid_s;
  logic                 rd_dirty_s;
  logic [TAG_W-1:0]     rd_tag_s;
  logic [LINE_BITS-1:0] rd_line_s;
  logic                 we_s;
  logic                 wr_dirty_s;
  logic [LINE_BITS-1:0] wr_line_s;
  logic                 merge_en_s;
  logic [WSEL_W-1:0]    merge_sel_s;
  logic [WORD_W-1:0]    merge_data_s;

  // Outside IDLE the pipeline inputs are ignored and the latched access drives the arrays
  assign idle_s      = (state_r == ST_IDLE);
  assign cur_addr_s  = idle_s ? p1_addr_i[ADDR_W-1:WSEL_LSB] : addr_r;
  assign idx_s       = cur_addr_s[TAG_LSB-1:OFFSET_W];
  assign tag_s       = cur_addr_s[ADDR_W-1:TAG_LSB];
  assign wsel_s      = cur_addr_s[OFFSET_W-1:WSEL_LSB];
  assign line_addr_s = {tag_s, idx_s, {OFFSET_W{1'b0}}};
  assign hit_s       = rd_valid_s && (rd_tag_s == tag_s);

  assign p1_stall_o  = p1_req_i & ~(idle_s & hit_s);
  assign p1_data_o   = (p1_req_i && idle_s && hit_s) ? rd_line_s[{wsel_s, 5'd0} +: WORD_W]
                                                     : {WORD_W{1'b0}};

  assign mem_enable_o = mem_enable_r;
  assign mem_write_o  = mem_write_r;
  assign mem_addr_o   = mem_addr_r;
  assign mem_data_o   = mem_data_r;

  // Array write port: store hits merge in place, FILL installs the refilled line
  always_comb begin
    we_s         = 1'b0;
    wr_dirty_s   = 1'b0;
    wr_line_s    = rd_line_s;
    merge_en_s   = 1'b0;
    merge_sel_s  = wsel_s;
    merge_data_s = p1_data_i;
    if (idle_s && p1_req_i && p1_write_i && hit_s) begin
      we_s       = 1'b1;
      wr_dirty_s = 1'b1;
      merge_en_s = 1'b1;
    end else if (state_r == ST_FILL) begin
      we_s         = 1'b1;
      wr_dirty_s   = write_r;
      wr_line_s    = fill_line_r;
      merge_en_s   = write_r;
      merge_data_s = wdata_r;
    end else begin
      we_s = 1'b0;
    end
  end

  dcache_sram #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_sram (
    .clk        (clk_i),
    .clr        (rst_i),
    .index      (idx_s),
    .rd_valid   (rd_valid_s),
    .rd_dirty   (rd_dirty_s),
    .rd_tag     (rd_tag_s),
    .rd_line    (rd_line_s),
    .we         (we_s),
    .wr_tag     (tag_s),
    .wr_valid   (1'b1),
    .wr_dirty   (wr_dirty_s),
    .wr_line    (wr_line_s),
    .merge_en   (merge_en_s),
    .merge_sel  (merge_sel_s),
    .merge_data (merge_data_s)
  );

  // Miss FSM: latches the access and owns the registered memory handshake
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= ST_IDLE;
      addr_r       <= '0;
      write_r      <= 1'b0;
      wdata_r      <= '0;
      fill_line_r  <= '0;
      mem_enable_r <= 1'b0;
      mem_write_r  <= 1'b0;
      mem_addr_r   <= '0;
      mem_data_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (p1_req_i && !hit_s) begin
            addr_r       <= p1_addr_i[ADDR_W-1:WSEL_LSB];
            write_r      <= p1_write_i;
            wdata_r      <= p1_data_i;
            mem_enable_r <= 1'b1;
            if (rd_valid_s && rd_dirty_s) begin
              state_r     <= ST_WRITEBACK;
              mem_write_r <= 1'b1;
              mem_addr_r  <= {rd_tag_s, idx_s, {OFFSET_W{1'b0}}};
              mem_data_r  <= rd_line_s;
            end else begin
              state_r     <= ST_REFILL;
              mem_write_r <= 1'b0;
              mem_addr_r  <= line_addr_s;
            end
          end
        end
        ST_WRITEBACK: begin
          if (mem_ack_i) begin
            state_r     <= ST_REFILL;
            mem_write_r <= 1'b0;
            mem_addr_r  <= line_addr_s;
          end
        end
        ST_REFILL: begin
          if (mem_ack_i) begin
            state_r      <= ST_FILL;
            fill_line_r  <= mem_data_i;
            mem_enable_r <= 1'b0;
          end
        end
        ST_FILL: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r      <= ST_IDLE;
          mem_enable_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
